// File: rtl/led_mode_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : led_ctrl_pkg                                                   |
// | Purpose   : Mode encoding, direction constants and counter-width helpers   |
// |             shared by the Go Board LED mode controller.                    |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    localparam logic c_DIR_FWD = 1'b0;
    localparam logic c_DIR_REV = 1'b1;

    // Step counter holds 0..n-1.
    function automatic int step_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Hold counter saturates at n, so it must represent 0..n.
    function automatic int hold_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_mode_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : led_mode_controller_if                                         |
// | Purpose   : Debounced switch inputs and LED/mode outputs of the controller.|
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface led_mode_controller_if;
    logic       i_Switch_1;
    logic       i_Switch_2;
    logic       i_Switch_3;
    logic       i_Switch_4;
    logic       o_LED_1;
    logic       o_LED_2;
    logic       o_LED_3;
    logic       o_LED_4;
    logic [1:0] o_Mode;

    modport master (
        output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        input  o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Mode
    );

    modport slave (
        input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
        output o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Mode
    );
endinterface
`default_nettype wire

// File: rtl/led_mode_controller_switch_press_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : switch_press_detector                                          |
// | Purpose   : Release-edge short press and held long press pulses for one    |
// |             debounced switch; LONG_PRESS_CLKS = 0 disables long presses.   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module switch_press_detector
    import led_ctrl_pkg::*;
#(
    parameter int LONG_PRESS_CLKS = 8
) (
    input  wire  i_Clk,
    input  wire  i_Rst_L,
    input  wire  i_Switch,
    output logic o_Short_Press,
    output logic o_Long_Press
);

    logic r_prev;
    logic r_swallow;
    logic w_fall;
    logic w_long;

    assign w_fall = r_prev & ~i_Switch;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_Switch;
        end
    end

    generate
        if (LONG_PRESS_CLKS > 0) begin : g_hold
            localparam int             c_W    = hold_width(LONG_PRESS_CLKS);
            localparam logic [c_W-1:0] c_MAX  = c_W'(LONG_PRESS_CLKS);
            localparam logic [c_W-1:0] c_FIRE = c_W'(LONG_PRESS_CLKS - 1);

            logic [c_W-1:0] r_cnt;

            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    r_cnt <= '0;
                end else if (!i_Switch) begin
                    r_cnt <= '0;
                end else if (r_cnt != c_MAX) begin
                    r_cnt <= r_cnt + c_W'(1);
                end
            end

            // Saturation keeps the count from passing c_FIRE twice in one hold.
            assign w_long = i_Switch & (r_cnt == c_FIRE);
        end else begin : g_no_hold
            assign w_long = 1'b0;
        end
    endgenerate

    // Once a long press fires, its release must not also count as a short press.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_swallow <= 1'b0;
        end else if (w_long) begin
            r_swallow <= 1'b1;
        end else if (!i_Switch) begin
            r_swallow <= 1'b0;
        end
    end

    assign o_Short_Press = w_fall & ~r_swallow;
    assign o_Long_Press  = w_long;

endmodule
`default_nettype wire

// File: rtl/led_mode_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : led_mode_controller                                            |
// | Purpose   : OFF/TOGGLE/CHASE/BLINK mode sequencer for the four Go Board    |
// |             LEDs. Optional macro LED_DIM_EN adds PWM dimming of the LEDs.  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module led_mode_controller
    import led_ctrl_pkg::*;
#(
    parameter int CLKS_PER_STEP   = 6250000,
    parameter int LONG_PRESS_CLKS = 25000000
`ifdef LED_DIM_EN
    ,
    parameter int PWM_BITS        = 4,
    parameter int PWM_DUTY        = 4
`endif
) (
    input  wire                   i_Clk,
    input  wire                   i_Rst_L,
    led_mode_controller_if.slave  bus
);

    localparam int                  c_STEP_W    = step_width(CLKS_PER_STEP);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(CLKS_PER_STEP - 1);

    logic [3:0]          w_sw;
    logic [3:0]          w_short;
    logic [3:0]          w_long;
    logic                w_adv;
    logic                w_wrap;
    logic                w_dir_eff;
    logic [3:0]          w_pins;

    mode_t               r_mode;
    mode_t               w_mode_next;
    logic [3:0]          r_led;
    logic [3:0]          w_led_next;
    logic [c_STEP_W-1:0] r_step;
    logic [c_STEP_W-1:0] w_step_next;
    logic                r_dir;
    logic                w_dir_next;

    assign w_sw = {bus.i_Switch_4, bus.i_Switch_3, bus.i_Switch_2, bus.i_Switch_1};

    generate
        for (genvar k = 0; k < 4; k++) begin : g_sw
            switch_press_detector #(
                .LONG_PRESS_CLKS ((k == 0) ? LONG_PRESS_CLKS : 0)
            ) u_det (
                .i_Clk         (i_Clk),
                .i_Rst_L       (i_Rst_L),
                .i_Switch      (w_sw[k]),
                .o_Short_Press (w_short[k]),
                .o_Long_Press  (w_long[k])
            );
        end
    endgenerate

    // Switches 2-4 have long-press detection disabled, so only switch 1 contributes.
    assign w_adv     = |w_long;
    assign w_wrap    = (r_step == c_STEP_LAST);
    assign w_dir_eff = r_dir ^ w_short[1];

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_mode <= MODE_OFF;
            r_led  <= 4'b0000;
            r_step <= '0;
            r_dir  <= c_DIR_FWD;
        end else begin
            r_mode <= w_mode_next;
            r_led  <= w_led_next;
            r_step <= w_step_next;
            r_dir  <= w_dir_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        w_led_next  = r_led;
        w_step_next = r_step;
        w_dir_next  = r_dir;
        if (w_adv) begin
            // An advance discards any short press or step wrap in the same cycle.
            w_mode_next = next_mode(r_mode);
            w_step_next = '0;
            case (next_mode(r_mode))
                MODE_CHASE: w_led_next = 4'b0001;
                MODE_BLINK: w_led_next = 4'b1111;
                default:    w_led_next = 4'b0000;
            endcase
        end else begin
            case (r_mode)
                MODE_TOGGLE: w_led_next = r_led ^ w_short;
                MODE_CHASE: begin
                    w_dir_next  = w_dir_eff;
                    w_step_next = w_wrap ? '0 : r_step + c_STEP_W'(1);
                    if (w_wrap) begin
                        w_led_next = (w_dir_eff == c_DIR_FWD) ? {r_led[2:0], r_led[3]}
                                                              : {r_led[0], r_led[3:1]};
                    end
                end
                MODE_BLINK: begin
                    w_step_next = w_wrap ? '0 : r_step + c_STEP_W'(1);
                    if (w_wrap) begin
                        w_led_next = ~r_led;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LED_DIM_EN
    logic [PWM_BITS-1:0] r_pwm;
    logic [3:0]          r_led_out;
    logic                w_pwm_on;

    assign w_pwm_on = (32'(r_pwm) < 32'(PWM_DUTY));

    // Gate ahead of the output register so dimming adds no latency.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_pwm     <= '0;
            r_led_out <= 4'b0000;
        end else begin
            r_pwm     <= r_pwm + PWM_BITS'(1);
            r_led_out <= w_led_next & {4{w_pwm_on}};
        end
    end

    assign w_pins = r_led_out;
`else
    assign w_pins = r_led;
`endif

    assign bus.o_LED_1 = w_pins[0];
    assign bus.o_LED_2 = w_pins[1];
    assign bus.o_LED_3 = w_pins[2];
    assign bus.o_LED_4 = w_pins[3];
    assign bus.o_Mode  = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_led_mode_controller                                         |
// | Purpose   : Self-checking bench for led_mode_controller against a          |
// |             behavioural model of modes, presses and LED patterns.          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_led_mode_controller;

    localparam int c_STEP      = 4;
    localparam int c_LONG      = 8;
    localparam int c_PWM_BITS  = 2;
    localparam int c_PWM_DUTY  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    led_mode_controller_if bus ();

    led_mode_controller #(
        .CLKS_PER_STEP   (c_STEP),
        .LONG_PRESS_CLKS (c_LONG)
`ifdef LED_DIM_EN
        ,
        .PWM_BITS        (c_PWM_BITS),
        .PWM_DUTY        (c_PWM_DUTY)
`endif
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    // Behavioural model: mode number, toggle bits, chase position, blink phase.
    bit [1:0] m_mode;
    bit [3:0] m_tog;
    int       m_pos;
    bit       m_rev;
    bit       m_blink_on;
    int       m_phase;
    int       m_hold;
    bit       m_swallow;
    bit [3:0] m_prev;
    int       m_pwm;
    bit       m_gate;
    bit [3:0] m_out;

    task automatic model_reset();
        m_mode = 2'd0; m_tog = 4'b0; m_pos = 0; m_rev = 1'b0; m_blink_on = 1'b0;
        m_phase = 0; m_hold = 0; m_swallow = 1'b0; m_prev = 4'b0; m_pwm = 0;
        m_gate = 1'b1; m_out = 4'b0;
    endtask

    function automatic bit [3:0] model_leds();
        case (m_mode)
            2'd1:    return m_tog;
            2'd2:    return 4'b0001 << m_pos;
            2'd3:    return m_blink_on ? 4'b1111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_step(input bit [3:0] sw);
        bit [3:0] sp;
        bit       lp;
        lp = sw[0] && (m_hold == c_LONG - 1);
        sp = m_prev & ~sw;
        if (m_swallow) sp[0] = 1'b0;
        if (lp) m_swallow = 1'b1;
        else if (!sw[0]) m_swallow = 1'b0;
        m_hold = sw[0] ? ((m_hold < c_LONG) ? m_hold + 1 : c_LONG) : 0;
        m_prev = sw;
        if (lp) begin
            m_mode = m_mode + 2'd1; m_tog = 4'b0; m_pos = 0; m_phase = 0; m_blink_on = 1'b1;
        end else begin
            case (m_mode)
                2'd1: m_tog = m_tog ^ sp;
                2'd2: begin
                    if (sp[1]) m_rev = !m_rev;
                    if (m_phase == c_STEP - 1) begin
                        m_phase = 0;
                        m_pos   = m_rev ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
                    end else m_phase++;
                end
                2'd3: begin
                    if (m_phase == c_STEP - 1) begin
                        m_phase = 0; m_blink_on = !m_blink_on;
                    end else m_phase++;
                end
                default: ;
            endcase
        end
`ifdef LED_DIM_EN
        m_gate = (m_pwm < c_PWM_DUTY);
        m_pwm  = (m_pwm + 1) % (1 << c_PWM_BITS);
`else
        m_gate = 1'b1;
`endif
        m_out = model_leds() & {4{m_gate}};
    endtask

    function automatic logic [5:0] observed();
        return {bus.o_Mode, bus.o_LED_4, bus.o_LED_3, bus.o_LED_2, bus.o_LED_1};
    endfunction

    function automatic logic [5:0] expected();
        return {m_mode, m_out};
    endfunction

    function automatic bit [3:0] gated(input bit [3:0] v);
        return v & {4{m_gate}};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic cycle(input bit [3:0] sw);
        @(negedge clk);
        bus.i_Switch_1 = sw[0];
        bus.i_Switch_2 = sw[1];
        bus.i_Switch_3 = sw[2];
        bus.i_Switch_4 = sw[3];
        @(posedge clk);
        model_step(sw);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        #1 rst_n = 1'b0;
        model_reset();
        #1 got = observed();
        n_tests++;
        if (got !== 6'b0) begin n_fail++; $display("FAIL reset_state: got %b, expected %b", got, 6'b0); end
        release_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(4'b0000);
            got = observed(); n_tests++;
            if (got !== expected()) begin n_fail++; $display("FAIL idle: got %b, expected %b", got, expected()); end
        end
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 4; j++) begin
                cycle((j < 2) ? (4'b0001 << n) : 4'b0000);
                got = observed(); n_tests++;
                if (got !== expected()) begin n_fail++; $display("FAIL off_press sw%0d: got %b, expected %b", n + 1, got, expected()); end
            end
        end
        got = observed(); n_tests++;
        if (got !== 6'b0) begin n_fail++; $display("FAIL off_ignores_presses: got %b, expected %b", got, 6'b0); end
    endtask

    task automatic test_long_press();
        logic [5:0] got;
        logic [1:0] last_mode;
        int         changes = 0;
        int         first   = -1;
        last_mode = bus.o_Mode;
        for (int i = 1; i <= 10; i++) begin
            cycle(4'b0001);
            got = observed(); n_tests++;
            if (got !== expected()) begin n_fail++; $display("FAIL long_hold: got %b, expected %b", got, expected()); end
            if (got[5:4] !== last_mode) begin
                changes++;
                if (first < 0) first = i;
            end
            last_mode = got[5:4];
        end
        for (int i = 0; i < 2; i++) begin
            cycle(4'b0000);
            got = observed(); n_tests++;
            if (got !== expected()) begin n_fail++; $display("FAIL long_release: got %b, expected %b", got, expected()); end
        end
        n_tests++;
        if (changes != 1 || first < 8 || first > 9) begin
            n_fail++; $display("FAIL long_press_timing: got %0d changes at clk %0d, expected 1 change at clk 8..9", changes, first);
        end
        got = observed(); n_tests++;
        if (got !== {2'd1, 4'b0000}) begin n_fail++; $display("FAIL long_press_end: got %b, expected %b", got, {2'd1, 4'b0000}); end
    endtask

    task automatic test_toggle();
        logic [5:0] got;
        repeat (3) cycle(4'b0100);
        got = observed(); n_tests++;
        if (got !== {2'd1, 4'b0000}) begin n_fail++; $display("FAIL toggle_before_release: got %b, expected %b", got, {2'd1, 4'b0000}); end
        cycle(4'b0000);
        got = observed(); n_tests++;
        if (got !== {2'd1, gated(4'b0100)}) begin n_fail++; $display("FAIL toggle_sw3: got %b, expected %b", got, {2'd1, gated(4'b0100)}); end
        repeat (2) cycle(4'b1001);
        cycle(4'b0000);
        got = observed(); n_tests++;
        if (got !== {2'd1, gated(4'b1101)}) begin n_fail++; $display("FAIL toggle_sw1_sw4: got %b, expected %b", got, {2'd1, gated(4'b1101)}); end
        cycle(4'b0000);
        got = observed(); n_tests++;
        if (got !== expected()) begin n_fail++; $display("FAIL toggle_hold: got %b, expected %b", got, expected()); end
    endtask

    task automatic test_chase();
        logic [5:0] got;
        bit [3:0]   seq [0:6];
        bit [3:0]   exp_l;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        repeat (c_LONG) cycle(4'b0001);
        got = observed(); n_tests++;
        if (got !== {2'd2, gated(4'b0001)}) begin n_fail++; $display("FAIL chase_entry: got %b, expected %b", got, {2'd2, gated(4'b0001)}); end
        for (int t = 1; t <= 32; t++) begin
            cycle((t == 25) ? 4'b0010 : 4'b0000);
            got = observed(); n_tests++;
            if (got !== expected()) begin n_fail++; $display("FAIL chase_model t=%0d: got %b, expected %b", t, got, expected()); end
            if (t < 28)      exp_l = seq[t / 4];
            else if (t < 32) exp_l = 4'b0010;
            else             exp_l = 4'b0001;
            n_tests++;
            if (got !== {2'd2, gated(exp_l)}) begin n_fail++; $display("FAIL chase_seq t=%0d: got %b, expected %b", t, got, {2'd2, gated(exp_l)}); end
        end
    endtask

    task automatic test_blink();
        logic [5:0] got;
        bit [3:0]   exp_l;
        repeat (c_LONG) cycle(4'b0001);
        got = observed(); n_tests++;
        if (got !== {2'd3, gated(4'b1111)}) begin n_fail++; $display("FAIL blink_entry: got %b, expected %b", got, {2'd3, gated(4'b1111)}); end
        for (int t = 1; t <= 12; t++) begin
            cycle(4'b0000);
            exp_l = (((t / 4) % 2) == 0) ? 4'b1111 : 4'b0000;
            got = observed(); n_tests++;
            if (got !== {2'd3, gated(exp_l)}) begin n_fail++; $display("FAIL blink_seq t=%0d: got %b, expected %b", t, got, {2'd3, gated(exp_l)}); end
        end
        // Align so the advancing edge is also a step-wrap edge.
        for (int i = 0; i < 8 && m_phase != 0; i++) cycle(4'b0000);
        for (int i = 0; i < c_LONG; i++) begin
            cycle(4'b0001);
            got = observed(); n_tests++;
            if (got !== expected()) begin n_fail++; $display("FAIL blink_hold: got %b, expected %b", got, expected()); end
        end
        got = observed(); n_tests++;
        if (got !== 6'b0) begin n_fail++; $display("FAIL blink_adv_on_wrap: got %b, expected %b", got, 6'b0); end
        cycle(4'b0000);
        got = observed(); n_tests++;
        if (got !== 6'b0) begin n_fail++; $display("FAIL off_after_release: got %b, expected %b", got, 6'b0); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] got;
        int         first = -1;
        for (int a = 0; a < 2; a++) begin
            repeat (c_LONG) cycle(4'b0001);
            cycle(4'b0000);
        end
        repeat (5) cycle(4'b0000);
        got = observed(); n_tests++;
        if (got !== expected()) begin n_fail++; $display("FAIL pre_reset_chase: got %b, expected %b", got, expected()); end
        do_reset();
        got = observed(); n_tests++;
        if (got !== 6'b0) begin n_fail++; $display("FAIL reset_mid_chase: got %b, expected %b", got, 6'b0); end
        release_reset();
        repeat (5) cycle(4'b0001);
        do_reset();
        got = observed(); n_tests++;
        if (got !== 6'b0) begin n_fail++; $display("FAIL reset_mid_hold: got %b, expected %b", got, 6'b0); end
        release_reset();
        for (int i = 1; i <= 20 && first < 0; i++) begin
            cycle(4'b0001);
            got = observed(); n_tests++;
            if (got !== expected()) begin n_fail++; $display("FAIL post_reset_hold: got %b, expected %b", got, expected()); end
            if (got[5:4] !== 2'd0) first = i;
        end
        n_tests++;
        if (first != c_LONG) begin n_fail++; $display("FAIL hold_after_reset: got advance at clk %0d, expected clk %0d", first, c_LONG); end
        repeat (2) cycle(4'b0000);
    endtask

    task automatic test_random();
        logic [5:0] got;
        bit [3:0]   sw = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 8) == 0) sw[0] = ~sw[0];
            for (int n = 1; n < 4; n++) begin
                if ($urandom_range(0, 3) == 0) sw[n] = ~sw[n];
            end
            cycle(sw);
            got = observed(); n_tests++;
            if (got !== expected()) begin n_fail++; $display("FAIL random i=%0d sw=%b: got %b, expected %b", i, sw, got, expected()); end
        end
    endtask

    initial begin
        bus.i_Switch_1 = 1'b0;
        bus.i_Switch_2 = 1'b0;
        bus.i_Switch_3 = 1'b0;
        bus.i_Switch_4 = 1'b0;
        model_reset();
        test_reset();
        test_long_press();
        test_toggle();
        test_chase();
        test_blink();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion earlier", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
